booth_mul_seq: RTL and testbench

Iterative radix-2 Booth multiply sequencer for the miniSRC ALU MUL instruction. It replaces the single-cycle combinational Booth array with a one-add-per-cycle engine: the control unit pulses `start` with the operands and waits for `done`. The engine then delivers the signed 64-bit product on the HI/LO register inputs, one bit scanned per cycle.

---
 rtl/booth_mul_seq.sv | 135 +++++++++++++
 tb/tb_booth_mul_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth multiplier: one add/subtract and one arithmetic shift per cycle.
// A pulse on start launches a WIDTH-step signed multiply; done pulses when {hi, lo} is valid.
// Optional feature macro: BOOTH_MUL_OVF_EN adds a registered signed-overflow flag (ovf).
module booth_mul_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef BOOTH_MUL_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   m_q, m_d;      // sign-extended multiplicand
  logic [WIDTH:0]   acc_q, acc_d;  // one extra bit so that -(-2^(W-1)) cannot overflow
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic             last;

  // One Booth step: conditional add/subtract of M, then arithmetic shift of {acc, Q, q_m1}.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
    acc_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh   = {sum[0], q_q[WIDTH-1:1]};
  end

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath update; every register holds unless explicitly loaded.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start && !cancel) begin
          state_d = StCalc;
          m_d     = {a[WIDTH-1], a};
          acc_d   = '0;
          q_d     = b;
          qm1_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StCalc: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_sh;
          q_d   = q_sh;
          qm1_d = q_q[0];
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            state_d = StDone;
            hi_d    = acc_sh[WIDTH-1:0];
            lo_d    = q_sh;
            // Product fits in WIDTH signed bits only if hi is pure sign extension of lo.
            ovf_d   = (acc_sh[WIDTH-1:0] != {WIDTH{q_sh[WIDTH-1]}});
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StCalc);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef BOOTH_MUL_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomized self-checking bench for booth_mul_seq.
module tb_booth_mul_seq;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef BOOTH_MUL_OVF_EN
  logic        ovf;
`endif

  int checks;
  int failures;
  int cyc;
  int nbusy;

  booth_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .cancel  (cancel),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
`ifdef BOOTH_MUL_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive start for one cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    nbusy = 0;
  endtask

  // Advance until done (bounded); cyc ends at the done cycle index.
  task automatic wait_done();
    while (!done && cyc < 40) begin
      nbusy += int'(busy);
      tick();
      cyc++;
    end
  endtask

  task automatic chk_prod(input string tag, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] p;
    p = 64'(longint'($signed(av)) * longint'($signed(bv)));
    issue(av, bv);
    wait_done();
    chk({tag, "_lat"}, 64'(cyc), 64'd33);
    chk({tag, "_prod"}, {hi, lo}, p);
`ifdef BOOTH_MUL_OVF_EN
    chk({tag, "_ovf"}, 64'(ovf), 64'(p[63:32] != {32{p[31]}}));
`endif
  endtask

  initial begin
    int ndone;
    logic [31:0] corner [5];
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    cancel   = 1'b0;
    a        = '0;
    b        = '0;
    cyc      = 0;
    nbusy    = 0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
`ifdef BOOTH_MUL_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    reset_n = 1'b1;
    tick();

    // 3 x 5 with full timing check
    issue(32'd3, 32'd5);
    wait_done();
    chk("t1_lat", 64'(cyc), 64'd33);
    chk("t1_busy_cycles", 64'(nbusy), 64'd32);
    chk("t1_busy_in_done", 64'(busy), 64'd0);
    chk("t1_hi", 64'(hi), 64'h0000_0000);
    chk("t1_lo", 64'(lo), 64'h0000_000F);
`ifdef BOOTH_MUL_OVF_EN
    chk("t1_ovf", 64'(ovf), 64'd0);
`endif
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_hold", {hi, lo}, 64'h0000_0000_0000_000F);

    // -7 x 6, then back-to-back 0x80000000^2 issued in the done cycle
    issue(32'hFFFF_FFF9, 32'd6);
    wait_done();
    chk("t2_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("t2_lo", 64'(lo), 64'hFFFF_FFD6);
`ifdef BOOTH_MUL_OVF_EN
    chk("t2_ovf", 64'(ovf), 64'd0);
`endif
    issue(32'h8000_0000, 32'h8000_0000);
    wait_done();
    chk("t3_lat", 64'(cyc), 64'd33);
    chk("t3_hi", 64'(hi), 64'h4000_0000);
    chk("t3_lo", 64'(lo), 64'h0000_0000);
`ifdef BOOTH_MUL_OVF_EN
    chk("t3_ovf", 64'(ovf), 64'd1);
`endif

    // 0x7FFFFFFF^2 with an ignored start at cycle 10
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    while (cyc < 10) begin
      tick();
      cyc++;
    end
    a     = 32'd2;
    b     = 32'd2;
    start = 1'b1;
    tick();
    cyc++;
    start = 1'b0;
    wait_done();
    chk("t4_lat", 64'(cyc), 64'd33);
    chk("t4_prod", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
    tick();
    chk("t4_no_restart", 64'(busy), 64'd0);

    // cancel at cycle 15
    issue(32'd11, 32'd13);
    while (cyc < 15) begin
      tick();
      cyc++;
    end
    chk("t5_busy_c15", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t5_busy_c16", 64'(busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      ndone += int'(done);
      tick();
    end
    chk("t5_no_done", 64'(ndone), 64'd0);
    chk("t5_hold", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
    issue(32'd2, 32'hFFFF_FFFF);
    wait_done();
    chk("t6_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    // async reset mid-CALC
    issue(32'h0001_2345, 32'h0000_0777);
    while (cyc < 5) begin
      tick();
      cyc++;
    end
    reset_n = 1'b0;
    #1;
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_hilo", {hi, lo}, 64'd0);
`ifdef BOOTH_MUL_OVF_EN
    chk("t7_ovf", 64'(ovf), 64'd0);
`endif
    tick();
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      ndone += int'(done);
      tick();
    end
    chk("t7_no_done", 64'(ndone), 64'd0);
    chk("t7_hilo_after", {hi, lo}, 64'd0);

    // corner pairs and random operands against a signed 64-bit reference
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h0000_0001;
    corner[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        chk_prod("corner", corner[i], corner[j]);
      end
    end
    for (int i = 0; i < 150; i++) begin
      chk_prod("rand", $urandom(), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
